// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core: default widths and the writeback FSM encoding.
package cpu_pkg;

  localparam int W_DEF = 8;
  localparam int D_DEF = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    COMMIT    = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_stage_if.sv
// Execute-to-writeback result handshake; master is execute, slave is wb_stage.
interface wb_stage_if
  import cpu_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int D = D_DEF
);

  logic         ExValid;
  logic         ExReady;
  logic         ExWrite;
  logic         ExIsLoad;
  logic [D-1:0] ExDest;
  logic [W-1:0] ExValue;

  modport master (
    output ExValid, ExWrite, ExIsLoad, ExDest, ExValue,
    input  ExReady
  );

  modport slave (
    input  ExValid, ExWrite, ExIsLoad, ExDest, ExValue,
    output ExReady
  );

endinterface

// File: rtl/wb_fwd_mux.sv
// Bypass select for one register-file read operand: pending write value wins on address match.
module wb_fwd_mux
  import cpu_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int D = D_DEF
) (
  input  logic         en,
  input  logic         wr,
  input  logic [D-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic [D-1:0] raddr,
  input  logic [W-1:0] rdata,
  output logic [W-1:0] fwd
);

  always_comb begin
    fwd = rdata;
    if (en && wr && (waddr == raddr)) fwd = wdata;
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: ALU/load results to the register-file write port.
// Optional operand bypass enabled by defining WB_FWD_EN.
module wb_stage
  import cpu_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int D       = D_DEF,
  parameter int MEM_LAT = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  wb_stage_if.slave     ex,
  input  logic [W-1:0]  MemReadData,
  input  logic [D-1:0]  Reg1,
  input  logic [D-1:0]  Reg2,
  input  logic [W-1:0]  RegData1,
  input  logic [W-1:0]  RegData2,
  output logic          WriteReg,
  output logic [D-1:0]  WReg,
  output logic [W-1:0]  WriteValue,
  output logic [W-1:0]  Fwd1,
  output logic [W-1:0]  Fwd2,
  output logic          Busy
);

  localparam int CW = $clog2(MEM_LAT + 1);

`ifdef WB_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  wb_state_t     state, state_nx;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          last_beat;

  assign accept    = ex.ExValid && ex.ExReady;
  assign last_beat = (cnt == CW'(1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  // COMMIT accepts like IDLE so back-to-back ALU results commit every cycle
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, COMMIT: begin
        state_nx = IDLE;
        if (accept && ex.ExWrite)
          state_nx = ex.ExIsLoad ? LOAD_WAIT : COMMIT;
      end
      LOAD_WAIT: if (last_beat) state_nx = COMMIT;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    ex.ExReady = (state != LOAD_WAIT);
    WriteReg   = (state == COMMIT);
    Busy       = (state == LOAD_WAIT);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt        <= '0;
      WReg       <= '0;
      WriteValue <= '0;
    end else begin
      if (state == LOAD_WAIT) begin
        cnt <= cnt - CW'(1);
        if (last_beat) WriteValue <= MemReadData;
      end
      if (accept && ex.ExWrite) begin
        WReg <= ex.ExDest;
        if (ex.ExIsLoad) cnt        <= CW'(MEM_LAT);
        else             WriteValue <= ex.ExValue;
      end
    end
  end

  wb_fwd_mux #(.W(W), .D(D)) u_fwd1 (
    .en    (FWD_EN),
    .wr    (WriteReg),
    .waddr (WReg),
    .wdata (WriteValue),
    .raddr (Reg1),
    .rdata (RegData1),
    .fwd   (Fwd1)
  );

  wb_fwd_mux #(.W(W), .D(D)) u_fwd2 (
    .en    (FWD_EN),
    .wr    (WriteReg),
    .waddr (WReg),
    .wdata (WriteValue),
    .raddr (Reg2),
    .rdata (RegData2),
    .fwd   (Fwd2)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: scenario tasks plus a write-port scoreboard.
module tb_wb_stage;

  localparam int W       = 8;
  localparam int D       = 3;
  localparam int MEM_LAT = 2;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [W-1:0] MemReadData;
  logic [D-1:0] Reg1, Reg2;
  logic [W-1:0] RegData1, RegData2;
  logic         WriteReg;
  logic [D-1:0] WReg;
  logic [W-1:0] WriteValue;
  logic [W-1:0] Fwd1, Fwd2;
  logic         Busy;

  int passed = 0;
  int total  = 0;
  logic [D+W-1:0] sb_q[$];

  wb_stage_if #(.W(W), .D(D)) ex ();

  wb_stage #(.W(W), .D(D), .MEM_LAT(MEM_LAT)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .ex          (ex.slave),
    .MemReadData (MemReadData),
    .Reg1        (Reg1),
    .Reg2        (Reg2),
    .RegData1    (RegData1),
    .RegData2    (RegData2),
    .WriteReg    (WriteReg),
    .WReg        (WReg),
    .WriteValue  (WriteValue),
    .Fwd1        (Fwd1),
    .Fwd2        (Fwd2),
    .Busy        (Busy)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: every write-port pulse must match the oldest expected write
  always @(negedge CLK) begin
    if (RESET !== 1'b1 && WriteReg === 1'b1) begin
      total++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected_write: got WReg=%0d WriteValue=%02h, expected no write", WReg, WriteValue);
      end else begin
        logic [D+W-1:0] exp;
        exp = sb_q.pop_front();
        if ({WReg, WriteValue} !== exp)
          $display("FAIL sb_write: got WReg=%0d WriteValue=%02h, expected WReg=%0d WriteValue=%02h",
                   WReg, WriteValue, exp[D+W-1:W], exp[W-1:0]);
        else passed++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1);
  end

  task automatic drive_idle();
    ex.ExValid  = 1'b0;
    ex.ExWrite  = 1'b0;
    ex.ExIsLoad = 1'b0;
    ex.ExDest   = '0;
    ex.ExValue  = '0;
  endtask

  task automatic drive_xfer(input logic wr, input logic ld, input logic [D-1:0] dst, input logic [W-1:0] val);
    ex.ExValid  = 1'b1;
    ex.ExWrite  = wr;
    ex.ExIsLoad = ld;
    ex.ExDest   = dst;
    ex.ExValue  = val;
  endtask

  task automatic test_reset();
    drive_idle();
    MemReadData = '0;
    Reg1 = '0; Reg2 = '0; RegData1 = '0; RegData2 = '0;
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    total++;
    if ({ex.ExReady, WriteReg, WReg, WriteValue, Busy} !== {1'b1, 1'b0, 3'd0, 8'h00, 1'b0})
      $display("FAIL reset_state: got ExReady=%b WriteReg=%b WReg=%0d WriteValue=%02h Busy=%b, expected 1 0 0 00 0",
               ex.ExReady, WriteReg, WReg, WriteValue, Busy);
    else passed++;
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_alu();
    drive_xfer(1'b1, 1'b0, 3'd3, 8'h5A);
    sb_q.push_back({3'd3, 8'h5A});
    @(negedge CLK);
    drive_idle();
    total++;
    if ({WriteReg, WReg, WriteValue} !== {1'b1, 3'd3, 8'h5A})
      $display("FAIL alu_commit: got WriteReg=%b WReg=%0d WriteValue=%02h, expected 1 3 5a", WriteReg, WReg, WriteValue);
    else passed++;
    @(negedge CLK);
    total++;
    if ({WriteReg, WReg, WriteValue} !== {1'b0, 3'd3, 8'h5A})
      $display("FAIL alu_after: got WriteReg=%b WReg=%0d WriteValue=%02h, expected 0 3 5a (held)", WriteReg, WReg, WriteValue);
    else passed++;
  endtask

  task automatic test_back_to_back();
    drive_xfer(1'b1, 1'b0, 3'd1, 8'h11);
    sb_q.push_back({3'd1, 8'h11});
    @(negedge CLK);
    total++;
    if ({WriteReg, ex.ExReady} !== 2'b11)
      $display("FAIL b2b_first: got WriteReg=%b ExReady=%b, expected 1 1", WriteReg, ex.ExReady);
    else passed++;
    drive_xfer(1'b1, 1'b0, 3'd2, 8'h22);
    sb_q.push_back({3'd2, 8'h22});
    @(negedge CLK);
    drive_idle();
    total++;
    if ({WriteReg, WReg, WriteValue, ex.ExReady} !== {1'b1, 3'd2, 8'h22, 1'b1})
      $display("FAIL b2b_second: got WriteReg=%b WReg=%0d WriteValue=%02h ExReady=%b, expected 1 2 22 1",
               WriteReg, WReg, WriteValue, ex.ExReady);
    else passed++;
    @(negedge CLK);
    total++;
    if (WriteReg !== 1'b0)
      $display("FAIL b2b_end: got WriteReg=%b, expected 0", WriteReg);
    else passed++;
  endtask

  task automatic test_load();
    MemReadData = 8'h99;
    drive_xfer(1'b1, 1'b1, 3'd6, 8'hEE);
    sb_q.push_back({3'd6, 8'hC3});
    @(negedge CLK);
    drive_idle();
    for (int i = 0; i < MEM_LAT; i++) begin
      total++;
      if ({ex.ExReady, Busy, WriteReg} !== 3'b010)
        $display("FAIL load_wait[%0d]: got ExReady=%b Busy=%b WriteReg=%b, expected 0 1 0", i, ex.ExReady, Busy, WriteReg);
      else passed++;
      // only the edge MEM_LAT after acceptance may sample the memory data
      MemReadData = (i == MEM_LAT - 1) ? 8'hC3 : 8'h99;
      @(negedge CLK);
      MemReadData = 8'h66;
    end
    total++;
    if ({WriteReg, WReg, WriteValue, Busy, ex.ExReady} !== {1'b1, 3'd6, 8'hC3, 1'b0, 1'b1})
      $display("FAIL load_commit: got WriteReg=%b WReg=%0d WriteValue=%02h Busy=%b ExReady=%b, expected 1 6 c3 0 1",
               WriteReg, WReg, WriteValue, Busy, ex.ExReady);
    else passed++;
    @(negedge CLK);
    MemReadData = '0;
  endtask

  task automatic test_nowrite();
    drive_xfer(1'b0, 1'b0, 3'd4, 8'hFF);
    @(negedge CLK);
    drive_idle();
    total++;
    if ({WriteReg, Busy, ex.ExReady} !== 3'b001)
      $display("FAIL nowrite: got WriteReg=%b Busy=%b ExReady=%b, expected 0 0 1", WriteReg, Busy, ex.ExReady);
    else passed++;
    @(negedge CLK);
    total++;
    if (WriteReg !== 1'b0)
      $display("FAIL nowrite_after: got WriteReg=%b, expected 0", WriteReg);
    else passed++;
  endtask

  task automatic test_forward();
    logic [W-1:0] exp1, exp2;
    drive_xfer(1'b1, 1'b0, 3'd2, 8'h7E);
    sb_q.push_back({3'd2, 8'h7E});
    Reg1 = 3'd2; RegData1 = 8'h00;
    Reg2 = 3'd2; RegData2 = 8'h44;
    @(negedge CLK);
    drive_idle();
`ifdef WB_FWD_EN
    exp1 = 8'h7E; exp2 = 8'h7E;
`else
    exp1 = 8'h00; exp2 = 8'h44;
`endif
    total++;
    if (Fwd1 !== exp1)
      $display("FAIL fwd1_match: got Fwd1=%02h, expected %02h", Fwd1, exp1);
    else passed++;
    total++;
    if (Fwd2 !== exp2)
      $display("FAIL fwd2_match: got Fwd2=%02h, expected %02h", Fwd2, exp2);
    else passed++;
    Reg1 = 3'd5; RegData1 = 8'h33;
    #1;
    total++;
    if (Fwd1 !== 8'h33)
      $display("FAIL fwd1_nomatch: got Fwd1=%02h, expected 33", Fwd1);
    else passed++;
    @(negedge CLK);
    total++;
    if (Fwd2 !== 8'h44)
      $display("FAIL fwd2_idle: got Fwd2=%02h, expected 44", Fwd2);
    else passed++;
    Reg1 = '0; Reg2 = '0; RegData1 = '0; RegData2 = '0;
  endtask

  task automatic test_reset_mid_load();
    MemReadData = 8'hA5;
    drive_xfer(1'b1, 1'b1, 3'd1, 8'h00);
    @(negedge CLK);
    drive_idle();
    total++;
    if (Busy !== 1'b1)
      $display("FAIL rst_load_busy: got Busy=%b, expected 1", Busy);
    else passed++;
    #1 RESET = 1'b1;
    #1;
    total++;
    if ({Busy, ex.ExReady, WriteReg} !== 3'b010)
      $display("FAIL rst_async: got Busy=%b ExReady=%b WriteReg=%b, expected 0 1 0", Busy, ex.ExReady, WriteReg);
    else passed++;
    @(negedge CLK);
    RESET = 1'b0;
    repeat (MEM_LAT + 2) @(negedge CLK);
    total++;
    if ({WriteReg, WReg, WriteValue, Busy} !== {1'b0, 3'd0, 8'h00, 1'b0})
      $display("FAIL rst_no_write: got WriteReg=%b WReg=%0d WriteValue=%02h Busy=%b, expected 0 0 00 0",
               WriteReg, WReg, WriteValue, Busy);
    else passed++;
    MemReadData = '0;
  endtask

  task automatic test_drain();
    total++;
    if (sb_q.size() != 0)
      $display("FAIL sb_drain: got %0d pending writes, expected 0", sb_q.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_load();
    test_nowrite();
    test_forward();
    test_reset_mid_load();
    test_drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
